// File: rtl/health_alarm_controller_if.sv
// Sample/alarm bundle between the Phase1 health monitor, the alarm stage and
// the nurse-station display. The slave side is the alarm controller.
interface health_alarm_controller_if;
    // Sample stream from HealthcareSystemPhase1
    logic       sampleValid;
    logic       presureAbnormality;
    logic       bloodAbnormality;
    logic [3:0] glycemicIndex;
    logic       lowTempAbnormality;
    logic       highTempAbnormality;

    // Operator acknowledge from the nurse station
    logic       alarmAck;

    // Alarm status toward the display
    logic       alarmActive;
    logic       warnActive;
    logic [1:0] alarmState;
    logic [4:0] alarmCause;
    logic [7:0] eventCount;
    logic [3:0] peakGlycemic;

    modport master (
        output sampleValid,
        output presureAbnormality,
        output bloodAbnormality,
        output glycemicIndex,
        output lowTempAbnormality,
        output highTempAbnormality,
        output alarmAck,
        input  alarmActive,
        input  warnActive,
        input  alarmState,
        input  alarmCause,
        input  eventCount,
        input  peakGlycemic
    );

    modport slave (
        input  sampleValid,
        input  presureAbnormality,
        input  bloodAbnormality,
        input  glycemicIndex,
        input  lowTempAbnormality,
        input  highTempAbnormality,
        input  alarmAck,
        output alarmActive,
        output warnActive,
        output alarmState,
        output alarmCause,
        output eventCount,
        output peakGlycemic
    );
endinterface

// File: rtl/health_alarm_controller.sv
// Alarm stage behind HealthcareSystemPhase1: per-source debounce, then a
// NORMAL/WARN/ALARM/ACKED machine with latched cause, event count and peak glycemic.
module health_alarm_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GLYCEMIC_HIGH   = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    health_alarm_controller_if.slave      bus
);
    localparam int         NUM_SOURCES = 5;
    localparam logic [3:0] DEBOUNCE_MAX = 4'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        WARN   = 2'b01,
        ALARM  = 2'b10,
        ACKED  = 2'b11
    } stateT;

    stateT                  stateReg;
    logic                   alarmActiveReg;
    logic                   warnActiveReg;
    logic [4:0]             alarmCauseReg;
    logic [7:0]             eventCountReg;
    logic [3:0]             peakGlycemicReg;

    logic [NUM_SOURCES-1:0] raw;
    logic [NUM_SOURCES-1:0] conf;
    logic [NUM_SOURCES-1:0] counterIsZero;
    logic [3:0]             persistCountReg [NUM_SOURCES];

    logic                   anyConf;
    logic                   anyRaw;
    logic                   newConf;
    logic                   allCountersZero;
    logic [7:0]             eventCountNext;

    // Raw bit order matches alarmCause so conf can be latched directly.
    assign raw = {
        bus.highTempAbnormality,
        bus.lowTempAbnormality,
        (32'(bus.glycemicIndex) >= GLYCEMIC_HIGH),
        bus.bloodAbnormality,
        bus.presureAbnormality
    };

    generate
        for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : gPersist
            always_ff @(posedge clk) begin
                if (rst) begin
                    persistCountReg[gi] <= 4'd0;
                end else if (bus.sampleValid) begin
                    if (!raw[gi]) begin
                        persistCountReg[gi] <= 4'd0;
                    end else if (persistCountReg[gi] != DEBOUNCE_MAX) begin
                        persistCountReg[gi] <= persistCountReg[gi] + 4'd1;
                    end
                end
            end

            assign conf[gi]          = (persistCountReg[gi] == DEBOUNCE_MAX);
            assign counterIsZero[gi] = (persistCountReg[gi] == 4'd0);
        end
    endgenerate

    assign anyConf         = |conf;
    assign anyRaw          = |raw;
    assign newConf         = |(conf & ~alarmCauseReg);
    assign allCountersZero = &counterIsZero;
    assign eventCountNext  = (eventCountReg == 8'hFF) ? eventCountReg : eventCountReg + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg       <= NORMAL;
            alarmActiveReg <= 1'b0;
            warnActiveReg  <= 1'b0;
            alarmCauseReg  <= 5'd0;
            eventCountReg  <= 8'd0;
        end else begin
            case (stateReg)
                NORMAL, WARN: begin
                    if (anyConf) begin
                        stateReg       <= ALARM;
                        alarmActiveReg <= 1'b1;
                        warnActiveReg  <= 1'b0;
                        alarmCauseReg  <= conf;
                        eventCountReg  <= eventCountNext;
                    end else if (stateReg == NORMAL && bus.sampleValid && anyRaw) begin
                        stateReg       <= WARN;
                        warnActiveReg  <= 1'b1;
                    end else if (stateReg == WARN && bus.sampleValid && !anyRaw) begin
                        stateReg       <= NORMAL;
                        warnActiveReg  <= 1'b0;
                    end
                end

                ALARM: begin
                    // Ack takes priority; a source confirming on the same edge is
                    // left out of the cause so ACKED sees it as new and re-alarms.
                    if (bus.alarmAck) begin
                        stateReg       <= ACKED;
                        alarmActiveReg <= 1'b0;
                    end else begin
                        alarmCauseReg  <= alarmCauseReg | conf;
                    end
                end

                ACKED: begin
                    if (newConf) begin
                        stateReg       <= ALARM;
                        alarmActiveReg <= 1'b1;
                        alarmCauseReg  <= alarmCauseReg | conf;
                        eventCountReg  <= eventCountNext;
                    end else if (allCountersZero) begin
                        stateReg       <= NORMAL;
                        alarmCauseReg  <= 5'd0;
                    end
                end

                default: begin
                    stateReg       <= NORMAL;
                    alarmActiveReg <= 1'b0;
                    warnActiveReg  <= 1'b0;
                end
            endcase
        end
    end

    // Peak is a display statistic; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            peakGlycemicReg <= 4'd0;
        end else if (bus.sampleValid && (bus.glycemicIndex > peakGlycemicReg)) begin
            peakGlycemicReg <= bus.glycemicIndex;
        end
    end

    assign bus.alarmActive  = alarmActiveReg;
    assign bus.warnActive   = warnActiveReg;
    assign bus.alarmState   = stateReg;
    assign bus.alarmCause   = alarmCauseReg;
    assign bus.eventCount   = eventCountReg;
    assign bus.peakGlycemic = peakGlycemicReg;
endmodule
